// File: rtl/mura_ctx_scheduler.sv
// Round-robin scheduler time-sharing one Gray-coded 3-state Moore step engine
// across N_REQ saved contexts; one step per cycle with a registered, id-tagged result.
module mura_ctx_scheduler #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   a,
   input  logic               clr,
   input  logic [ID_W-1:0]    clr_id,
   output logic [N_REQ-1:0]   gnt,
   output logic               y,
   output logic               y_vld,
   output logic [ID_W-1:0]    y_id,
   output logic [2*N_REQ-1:0] ctx_state
);
   localparam logic [1:0] S0 = 2'b00;
   localparam logic [1:0] S1 = 2'b01;
   localparam logic [1:0] S2 = 2'b11;

   logic [1:0]       ctx_r [N_REQ];
   logic [ID_W-1:0]  ptr_r;
   logic [N_REQ-1:0] gnt_r;
   logic             y_r;
   logic             y_vld_r;
   logic [ID_W-1:0]  y_id_r;

   logic [N_REQ-1:0] clr_hit_s;
   logic [N_REQ-1:0] elig_s;
   logic             found_s;
   logic [ID_W-1:0]  sel_s;
   logic [ID_W-1:0]  ptr_nxt_s;
   logic [N_REQ-1:0] gnt_nxt_s;
   logic [1:0]       nxt_s;
   logic             y_nxt_s;

   // Moore step engine: returns {y, next_state}; the unused code 10 recovers to S0
   function automatic logic [2:0] step_f(input logic [1:0] s, input logic b);
      logic [2:0] r;
      case (s)
         S0:      r = b ? {1'b1, S1} : {1'b0, S0};
         S1:      r = b ? {1'b1, S2} : {1'b1, S1};
         S2:      r = b ? {1'b0, S0} : {1'b1, S2};
         default: r = {1'b1, S0};
      endcase
      return r;
   endfunction

   // Eligibility: a requester just granted, or being cleared this cycle, sits out
   always_comb begin
      clr_hit_s = {N_REQ{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         clr_hit_s[i] = clr && (clr_id == ID_W'(i));
      end
      elig_s = req & ~gnt_r & ~clr_hit_s;
   end

   // Round-robin pick starting at the pointer, plus the step result for the winner
   always_comb begin
      logic [ID_W:0] idx_v;
      logic          take_v;
      logic [ID_W:0] inc_v;
      found_s = 1'b0;
      sel_s   = {ID_W{1'b0}};
      idx_v   = {(ID_W+1){1'b0}};
      take_v  = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx_v   = {1'b0, ptr_r} + (ID_W+1)'(k);
         idx_v   = (idx_v >= (ID_W+1)'(N_REQ)) ? (idx_v - (ID_W+1)'(N_REQ)) : idx_v;
         take_v  = en && !found_s && elig_s[idx_v[ID_W-1:0]];
         sel_s   = take_v ? idx_v[ID_W-1:0] : sel_s;
         found_s = found_s || take_v;
      end
      inc_v     = {1'b0, sel_s} + {{ID_W{1'b0}}, 1'b1};
      ptr_nxt_s = (inc_v == (ID_W+1)'(N_REQ)) ? {ID_W{1'b0}} : inc_v[ID_W-1:0];
      gnt_nxt_s = found_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << sel_s) : {N_REQ{1'b0}};
      {y_nxt_s, nxt_s} = step_f(ctx_r[sel_s], a[sel_s]);
   end

   // Context storage: a clear never coincides with a step of the same id
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_REQ; i++) ctx_r[i] <= S0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (clr_hit_s[i])
               ctx_r[i] <= S0;
            else if (found_s && (sel_s == ID_W'(i)))
               ctx_r[i] <= nxt_s;
            else
               ctx_r[i] <= ctx_r[i];
         end
      end
   end

   // Pointer and result registers; y/y_id hold across idle cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r   <= {ID_W{1'b0}};
         gnt_r   <= {N_REQ{1'b0}};
         y_r     <= 1'b0;
         y_vld_r <= 1'b0;
         y_id_r  <= {ID_W{1'b0}};
      end else begin
         gnt_r   <= gnt_nxt_s;
         y_vld_r <= found_s;
         if (found_s) begin
            ptr_r  <= ptr_nxt_s;
            y_r    <= y_nxt_s;
            y_id_r <= sel_s;
         end else begin
            ptr_r  <= ptr_r;
            y_r    <= y_r;
            y_id_r <= y_id_r;
         end
      end
   end

   assign gnt   = gnt_r;
   assign y     = y_r;
   assign y_vld = y_vld_r;
   assign y_id  = y_id_r;

   for (genvar g = 0; g < N_REQ; g++) begin : g_ctx_out
      assign ctx_state[2*g +: 2] = ctx_r[g];
   end
endmodule

// File: tb/tb_mura_ctx_scheduler.sv
// Bench for mura_ctx_scheduler: directed vector table, hand-written corner
// sequences and random traffic, all checked against a behavioural model.
module tb_mura_ctx_scheduler;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic [3:0]   req;
   logic [3:0]   a;
   logic         clr;
   logic [1:0]   clr_id;
   logic [3:0]   gnt;
   logic         y;
   logic         y_vld;
   logic [1:0]   y_id;
   logic [7:0]   ctx_state;

   int n_checks = 0;
   int n_errors = 0;

   // model: context held as position 0..2 along the S0->S1->S2 ring
   int         m_ctx [N];
   int         m_ptr;
   logic [3:0] m_gnt;
   logic       m_y;
   logic       m_vld;
   logic [1:0] m_id;

   typedef struct {
      logic [3:0] req;
      logic [3:0] a;
      logic [3:0] e_gnt;
      logic       e_y;
      logic       e_vld;
      logic [1:0] e_id;
      logic [7:0] e_ctx;
   } vec_t;

   vec_t tbl [18];

   mura_ctx_scheduler #(.N_REQ(4), .ID_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .a(a), .clr(clr),
      .clr_id(clr_id), .gnt(gnt), .y(y), .y_vld(y_vld), .y_id(y_id),
      .ctx_state(ctx_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_ctx_flat();
      logic [7:0] f;
      f = 8'h00;
      for (int i = 0; i < N; i++)
         f[2*i +: 2] = (m_ctx[i] == 0) ? 2'b00 : (m_ctx[i] == 1) ? 2'b01 : 2'b11;
      return f;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_ctx[i] = 0;
      m_ptr = 0; m_gnt = 4'b0000; m_y = 1'b0; m_vld = 1'b0; m_id = 2'd0;
   endtask

   // Advance the model by one clock using the inputs currently applied
   task automatic model_step();
      logic [3:0] elig;
      int sel;
      bit found;
      int s;
      bit b;
      found = 0; sel = 0;
      for (int i = 0; i < N; i++)
         elig[i] = req[i] && !m_gnt[i] && !(clr && (int'(clr_id) == i));
      if (en) begin
         for (int k = 0; k < N; k++) begin
            if (!found && elig[(m_ptr + k) % N]) begin
               found = 1;
               sel = (m_ptr + k) % N;
            end
         end
      end
      if (found) begin
         s = m_ctx[sel];
         b = a[sel];
         m_y = !((s == 0 && !b) || (s == 2 && b));
         m_ctx[sel] = b ? (s + 1) % 3 : s;
         m_gnt = 4'b0001 << sel;
         m_vld = 1'b1;
         m_id = 2'(sel);
         m_ptr = (sel + 1) % N;
      end else begin
         m_gnt = 4'b0000;
         m_vld = 1'b0;
      end
      if (clr) m_ctx[clr_id] = 0;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check("gnt", 32'(gnt), 32'(m_gnt));
      check("y", 32'(y), 32'(m_y));
      check("y_vld", 32'(y_vld), 32'(m_vld));
      check("y_id", 32'(y_id), 32'(m_id));
      check("ctx_state", 32'(ctx_state), 32'(m_ctx_flat()));
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] av, input logic e,
                        input logic c, input logic [1:0] cid);
      req = r; a = av; en = e; clr = c; clr_id = cid;
   endtask

   initial begin
      //           req      a        gnt      y     vld   id    ctx
      tbl[0]  = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h01};
      tbl[1]  = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h01};
      tbl[2]  = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h03};
      tbl[3]  = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h03};
      tbl[4]  = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 2'd0, 8'h00};
      tbl[5]  = '{4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
      tbl[6]  = '{4'b1111, 4'b0000, 4'b0010, 1'b0, 1'b1, 2'd1, 8'h00};
      tbl[7]  = '{4'b1111, 4'b0000, 4'b0100, 1'b0, 1'b1, 2'd2, 8'h00};
      tbl[8]  = '{4'b1111, 4'b0000, 4'b1000, 1'b0, 1'b1, 2'd3, 8'h00};
      tbl[9]  = '{4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b1, 2'd0, 8'h00};
      tbl[10] = '{4'b1111, 4'b0000, 4'b0010, 1'b0, 1'b1, 2'd1, 8'h00};
      tbl[11] = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h10};
      tbl[12] = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, 2'd2, 8'h10};
      tbl[13] = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h30};
      tbl[14] = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, 2'd2, 8'h30};
      tbl[15] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h30};
      tbl[16] = '{4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd2, 8'h30};
      tbl[17] = '{4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b1, 2'd2, 8'h00};

      rst_n = 1'b0;
      drive(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_gnt", 32'(gnt), 32'h0);
      check("reset_y", 32'(y), 32'h0);
      check("reset_vld", 32'(y_vld), 32'h0);
      check("reset_id", 32'(y_id), 32'h0);
      check("reset_ctx", 32'(ctx_state), 32'h0);
      rst_n = 1'b1;

      // directed table: single requester stepping, round robin, S2 behaviour
      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].req, tbl[i].a, 1'b1, 1'b0, 2'd0);
         cycle();
         check("tbl_gnt", 32'(gnt), 32'(tbl[i].e_gnt));
         check("tbl_y", 32'(y), 32'(tbl[i].e_y));
         check("tbl_vld", 32'(y_vld), 32'(tbl[i].e_vld));
         check("tbl_id", 32'(y_id), 32'(tbl[i].e_id));
         check("tbl_ctx", 32'(ctx_state), 32'(tbl[i].e_ctx));
      end

      // clear wins over a same-cycle request, which is then served from S0
      drive(4'b0010, 4'b0010, 1'b1, 1'b0, 2'd0);
      cycle();
      check("clr_pre_ctx", 32'(ctx_state), 32'h04);
      drive(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
      cycle();
      drive(4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1);
      cycle();
      check("clr_gnt", 32'(gnt), 32'h0);
      check("clr_ctx", 32'(ctx_state), 32'h00);
      drive(4'b0010, 4'b0010, 1'b1, 1'b0, 2'd0);
      cycle();
      check("clr_after_gnt", 32'(gnt), 32'h2);
      check("clr_after_ctx", 32'(ctx_state), 32'h04);

      // freeze with en=0, clear still applies, resume at saved pointer
      for (int i = 0; i < 5; i++) begin
         drive(4'b1111, 4'b0101, 1'b0, 1'b0, 2'd0);
         cycle();
         check("frz_gnt", 32'(gnt), 32'h0);
         check("frz_vld", 32'(y_vld), 32'h0);
         check("frz_ctx", 32'(ctx_state), 32'h04);
      end
      drive(4'b1111, 4'b0101, 1'b0, 1'b1, 2'd1);
      cycle();
      check("frz_clr_ctx", 32'(ctx_state), 32'h00);
      drive(4'b1111, 4'b0101, 1'b1, 1'b0, 2'd0);
      cycle();
      check("resume_gnt", 32'(gnt), 32'h4);
      check("resume_y", 32'(y), 32'h1);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 9) == 0),
               2'($urandom_range(0, 3)));
         cycle();
      end

      // reset mid-stream: immediate clear, then lowest requester wins
      drive(4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0);
      cycle();
      cycle();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("mid_rst_gnt", 32'(gnt), 32'h0);
      check("mid_rst_y", 32'(y), 32'h0);
      check("mid_rst_vld", 32'(y_vld), 32'h0);
      check("mid_rst_ctx", 32'(ctx_state), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(4'b1010, 4'b0000, 1'b1, 1'b0, 2'd0);
      cycle();
      check("post_rst_gnt", 32'(gnt), 32'h2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
